// File: rtl/serial_compare_pkg.sv
// serial_compare_pkg
// Shared definitions for the nibble-serial magnitude comparator.
//   CMP_GT / CMP_EQ / CMP_LT : one-hot result encoding (bit2 A>B, bit1 A==B,
//                              bit0 A<B), also used as the cascade encoding of
//                              nibble_cmp4.
//   CMP_NONE                 : result value shown between reset and first result.
//   state_e                  : controller state encoding.
package serial_compare_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_compare_nibble_cmp4.sv
// nibble_cmp4
// Combinational 4-bit magnitude comparator with a one-hot cascade input,
// behaving like a classic cascadable comparator slice: when the two nibbles
// differ the local result wins, otherwise the cascade input is passed through.
// Ports:
//   a_i    [3:0]  nibble of operand A
//   b_i    [3:0]  nibble of operand B
//   casc_i [2:0]  one-hot result of the more significant stages
//   res_o  [2:0]  one-hot result (100 A>B, 010 A==B, 001 A<B)
module nibble_cmp4
  import serial_compare_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] casc_i,
  output logic [2:0] res_o
);

  // Local inequality decides; equality defers to the cascade input.
  always_comb begin
    res_o = casc_i;
    if (a_i > b_i) begin
      res_o = CMP_GT;
    end else if (a_i < b_i) begin
      res_o = CMP_LT;
    end
  end

endmodule

// File: rtl/serial_compare.sv
// serial_compare
// Compares two W-bit operands (W = 4*NIBBLES) one nibble per clock, most
// significant nibble first, stopping at the first nibble that differs.
// Optional build macro: SERIAL_COMPARE_SIGNED_EN -- when defined the operands
// are treated as two's complement by inverting the sign bit of both operands
// in the MSB nibble compare; when undefined the compare is unsigned.
// Ports:
//   iClk            clock, all state changes on the rising edge
//   iRst            synchronous active-high reset
//   iStart          request pulse, accepted only in IDLE
//   iData_a [W-1:0] operand A, latched when the request is accepted
//   iData_b [W-1:0] operand B, latched when the request is accepted
//   oBusy           high while nibbles are being compared
//   oDone           one-cycle pulse when oData is updated
//   oData   [2:0]   one-hot result: 100 A>B, 010 A==B, 001 A<B
module serial_compare
  import serial_compare_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iStart,
  input  logic [4*NIBBLES-1:0]   iData_a,
  input  logic [4*NIBBLES-1:0]   iData_b,
  output logic                   oBusy,
  output logic                   oDone,
  output logic [2:0]             oData
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(NIBBLES - 1);

  state_e          state_q;
  logic [W-1:0]    opA_q;
  logic [W-1:0]    opB_q;
  logic [IW-1:0]   nibIdx_q;
  logic [2:0]      finalRes_q;

  logic [3:0]      nibA;
  logic [3:0]      nibB;
  logic [2:0]      nibRes;

  // Select the nibble pair addressed by the current index. The operand
  // registers themselves are never modified, so sign handling is applied
  // only to the selected MSB nibble copy.
  always_comb begin
    nibA = '0;
    nibB = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (nibIdx_q == IW'(n)) begin
        nibA = opA_q[n*4 +: 4];
        nibB = opB_q[n*4 +: 4];
      end
    end
`ifdef SERIAL_COMPARE_SIGNED_EN
    if (nibIdx_q == IDX_MSB) begin
      nibA[3] = ~nibA[3];
      nibB[3] = ~nibB[3];
    end
`endif
  end

  nibble_cmp4 uNibbleCmp (
    .a_i    (nibA),
    .b_i    (nibB),
    .casc_i (CMP_EQ),
    .res_o  (nibRes)
  );

  // Controller with registered outputs. The final result is held in
  // finalRes_q while in DONE and only copied to oData on the way back to
  // IDLE, so oData never shows a partial nibble result.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      nibIdx_q   <= '0;
      finalRes_q <= CMP_NONE;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
      oData      <= CMP_NONE;
    end else begin
      oDone <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iStart) begin
            opA_q    <= iData_a;
            opB_q    <= iData_b;
            nibIdx_q <= IDX_MSB;
            oBusy    <= 1'b1;
            state_q  <= CMP;
          end
        end
        CMP: begin
          if (nibRes != CMP_EQ) begin
            finalRes_q <= nibRes;
            oBusy      <= 1'b0;
            state_q    <= DONE;
          end else if (nibIdx_q == '0) begin
            finalRes_q <= CMP_EQ;
            oBusy      <= 1'b0;
            state_q    <= DONE;
          end else begin
            nibIdx_q <= nibIdx_q - 1'b1;
          end
        end
        DONE: begin
          oData   <= finalRes_q;
          oDone   <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          oBusy   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare.sv
// tb_serial_compare
// Self-checking bench for serial_compare (NIBBLES = 4). Expected results and
// latencies come from a behavioural model: a plain magnitude compare of the
// whole operands, and the count of nibbles examined derived from the position
// of the highest differing bit.
module tb_serial_compare;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic         busy;
  logic         done;
  logic [2:0]   data;

  int           testsRun = 0;
  int           testsFailed = 0;
  logic [2:0]   prevData;

  // 10-unit clock; inputs are driven and outputs sampled on the falling edge.
  always #5 clk = ~clk;

  serial_compare #(.NIBBLES(NIBBLES)) dut (
    .iClk    (clk),
    .iRst    (rst),
    .iStart  (start),
    .iData_a (dataA),
    .iData_b (dataB),
    .oBusy   (busy),
    .oDone   (done),
    .oData   (data)
  );

  // Whole-operand reference compare.
  function automatic logic [2:0] modelResult(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_COMPARE_SIGNED_EN
    if ($signed(a) > $signed(b)) return 3'b100;
    if ($signed(a) < $signed(b)) return 3'b001;
`else
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
`endif
    return 3'b010;
  endfunction

  // Number of nibbles looked at: up to and including the first differing one.
  function automatic int modelExamined(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    for (int p = W - 1; p >= 0; p--) begin
      if (x[p]) return NIBBLES - (p / 4);
    end
    return NIBBLES;
  endfunction

  // Comparison point: counts the test and reports a failure.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of
  // the oDone cycle, so a following call starts back-to-back.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit injectStart, input string tag);
    int         k;
    logic [2:0] exp;
    k   = modelExamined(a, b);
    exp = modelResult(a, b);
    start = 1'b1;
    dataA = a;
    dataB = b;
    @(negedge clk);
    checkOutput($sformatf("%s busy c0", tag), busy, 1);
    checkOutput($sformatf("%s done c0", tag), done, 0);
    // Scramble the inputs after acceptance; optionally request again mid-compare.
    dataA = ~a;
    dataB = W'($urandom);
    start = injectStart;
    for (int cyc = 1; cyc <= k + 1; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      checkOutput($sformatf("%s busy c%0d", tag, cyc), busy, (cyc < k));
      checkOutput($sformatf("%s done c%0d", tag, cyc), done, (cyc == k + 1));
      checkOutput($sformatf("%s data c%0d", tag, cyc), data, (cyc == k + 1) ? exp : prevData);
    end
    prevData = exp;
  endtask

  // Idle cycles: no pulses, no busy, result held.
  task automatic idleCheck(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s done i%0d", tag, i), done, 0);
      checkOutput($sformatf("%s busy i%0d", tag, i), busy, 0);
      checkOutput($sformatf("%s data i%0d", tag, i), data, prevData);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           sel;

    rst      = 1'b1;
    start    = 1'b0;
    dataA    = '0;
    dataB    = '0;
    prevData = 3'b000;

    // Reset, with a start request held during reset that must be overridden.
    repeat (2) @(negedge clk);
    start = 1'b1;
    dataA = 16'h1234;
    dataB = 16'h4321;
    @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset data", data, 3'b000);
    rst   = 1'b0;
    start = 1'b0;
    idleCheck(2, "postReset");

    // Equal operands: all nibbles examined.
    applyStimulus(16'h1234, 16'h1234, 1'b0, "equal");
    idleCheck(1, "gap1");

    // MSB nibble decides; result depends on signedness.
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, "msb");
`ifdef SERIAL_COMPARE_SIGNED_EN
    checkOutput("msb signed const", data, 3'b001);
`else
    checkOutput("msb unsigned const", data, 3'b100);
`endif
    idleCheck(1, "gap2");

    // Third nibble decides; a mid-compare request must be ignored.
    applyStimulus(16'h12A4, 16'h12B0, 1'b1, "ignore");
    checkOutput("ignore const", data, 3'b001);
    idleCheck(NIBBLES + 2, "noExtraDone");

    // Reset during the second compare cycle aborts without a pulse.
    start = 1'b1;
    dataA = 16'hFFFF;
    dataB = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort data", data, 3'b000);
    rst      = 1'b0;
    prevData = 3'b000;
    idleCheck(NIBBLES + 2, "postAbort");

    // Back-to-back requests.
    applyStimulus(16'h0001, 16'h0002, 1'b0, "b2b first");
    applyStimulus(16'h0000, 16'h0000, 1'b0, "b2b second");
    idleCheck(1, "gap3");

    // Random operands, biased so every examined-nibble count occurs.
    for (int i = 0; i < 40; i++) begin
      ra  = W'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0) begin
        rb = ra;
      end else if (sel <= NIBBLES) begin
        rb = ra ^ (W'($urandom_range(1, 15)) << (4 * (sel - 1)));
      end else begin
        rb = W'($urandom);
      end
      applyStimulus(ra, rb, bit'($urandom_range(0, 1)), $sformatf("rand%0d", i));
      idleCheck($urandom_range(0, 2), $sformatf("randGap%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
